// File: rtl/signed_mac_acc.sv
// Streaming signed/unsigned multiply-accumulate with per-frame saturated sum, peak magnitude, beat count and clip flag.
// Latency: the beat with in_last accepted in cycle N gives out_vld in cycle N+2; one beat per cycle when out_rdy=1.
// Backpressure: a result held with out_rdy=0 freezes the whole pipeline and drops in_rdy until the result is taken.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   tc                     0 unsigned, 1 two's complement; taken from the first beat of a frame
//   in_vld/in_rdy          operand beat handshake; dat_a, dat_b operands; in_last marks end of frame
//   out_vld/out_rdy        frame result handshake
//   acc_out                saturated frame sum (ACC_WIDTH)
//   peak_out               largest |product| seen in the frame (unsigned, A_WIDTH+B_WIDTH)
//   cnt_out                beats in the frame, saturating at all-ones
//   sat_flag               at least one accumulation step in the frame was clipped
module signed_mac_acc #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tc,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [A_WIDTH-1:0]         dat_a,
    input  logic [B_WIDTH-1:0]         dat_b,
    input  logic                       in_last,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [ACC_WIDTH-1:0]       acc_out,
    output logic [A_WIDTH+B_WIDTH-1:0] peak_out,
    output logic [CNT_WIDTH-1:0]       cnt_out,
    output logic                       sat_flag
);

    localparam int PRODUCT_WIDTH = A_WIDTH + B_WIDTH;
    localparam int EXT_WIDTH     = ACC_WIDTH + 1;

    localparam logic [PRODUCT_WIDTH-1:0] PROD_ONE = 1;
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = 1;
    localparam logic [ACC_WIDTH-1:0]     ACC_SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]     ACC_SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic                     busy_q,    busy_d;
    logic                     tc_lat_q,  tc_lat_d;

    logic                     p1_vld_q,  p1_vld_d;
    logic                     p1_last_q, p1_last_d;
    logic                     p1_tc_q,   p1_tc_d;
    logic [PRODUCT_WIDTH-1:0] p1_prod_q, p1_prod_d;

    logic [ACC_WIDTH-1:0]     acc_q,     acc_d;
    logic [PRODUCT_WIDTH-1:0] peak_q,    peak_d;
    logic [CNT_WIDTH-1:0]     cnt_q,     cnt_d;
    logic                     sat_q,     sat_d;

    logic                     out_vld_q,  out_vld_d;
    logic [ACC_WIDTH-1:0]     acc_out_q,  acc_out_d;
    logic [PRODUCT_WIDTH-1:0] peak_out_q, peak_out_d;
    logic [CNT_WIDTH-1:0]     cnt_out_q,  cnt_out_d;
    logic                     sat_out_q,  sat_out_d;

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic stall;
    logic accept;

    assign stall  = out_vld_q & ~out_rdy;
    assign in_rdy = ~stall;
    assign accept = in_vld & in_rdy;

    // ---------------------------------------------------------------
    // Stage 1: product in the frame's number convention
    // ---------------------------------------------------------------
    logic                     tc_frame;
    logic [PRODUCT_WIDTH-1:0] prod_u;
    logic [PRODUCT_WIDTH-1:0] prod_s;
    logic [PRODUCT_WIDTH-1:0] prod_s1;

    // The first beat of a frame decides tc; later beats reuse the latched value.
    assign tc_frame = busy_q ? tc_lat_q : tc;

    // Both operands are extended to the full product width so the low
    // PRODUCT_WIDTH bits of the multiply are exact in either convention.
    assign prod_u  = {{B_WIDTH{1'b0}}, dat_a} * {{A_WIDTH{1'b0}}, dat_b};
    assign prod_s  = $signed({{B_WIDTH{dat_a[A_WIDTH-1]}}, dat_a}) *
                     $signed({{A_WIDTH{dat_b[B_WIDTH-1]}}, dat_b});
    assign prod_s1 = tc_frame ? prod_s : prod_u;

    // ---------------------------------------------------------------
    // Stage 2: accumulate with clipping, track peak and count
    // ---------------------------------------------------------------
    logic [EXT_WIDTH-1:0]     prod_ext;
    logic [EXT_WIDTH-1:0]     acc_ext;
    logic [EXT_WIDTH-1:0]     sum;
    logic [ACC_WIDTH-1:0]     acc_next;
    logic                     clip;
    logic [PRODUCT_WIDTH-1:0] mag;
    logic [PRODUCT_WIDTH-1:0] peak_next;
    logic [CNT_WIDTH-1:0]     cnt_next;

    // One extra bit is enough for the sum of an in-range accumulator and
    // any product, since PRODUCT_WIDTH <= ACC_WIDTH.
    assign prod_ext = p1_tc_q ? {{(EXT_WIDTH-PRODUCT_WIDTH){p1_prod_q[PRODUCT_WIDTH-1]}}, p1_prod_q}
                              : {{(EXT_WIDTH-PRODUCT_WIDTH){1'b0}}, p1_prod_q};
    assign acc_ext  = p1_tc_q ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
    assign sum      = acc_ext + prod_ext;

    always_comb begin
        clip     = 1'b0;
        acc_next = sum[ACC_WIDTH-1:0];
        if (p1_tc_q) begin
            // Signed overflow shows as the top two bits of the wide sum disagreeing.
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                clip     = 1'b1;
                acc_next = sum[ACC_WIDTH] ? ACC_SMIN : ACC_SMAX;
            end
        end else if (sum[ACC_WIDTH]) begin
            clip     = 1'b1;
            acc_next = '1;
        end
    end

    // The most negative product cannot occur (one factor's minimum times the
    // other's minimum is positive), so negation always fits in PRODUCT_WIDTH.
    assign mag       = (p1_tc_q && p1_prod_q[PRODUCT_WIDTH-1]) ? (~p1_prod_q + PROD_ONE) : p1_prod_q;
    assign peak_next = (mag > peak_q) ? mag : peak_q;
    assign cnt_next  = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_ONE);

    // ---------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------
    always_comb begin
        busy_d     = busy_q;
        tc_lat_d   = tc_lat_q;
        p1_vld_d   = p1_vld_q;
        p1_last_d  = p1_last_q;
        p1_tc_d    = p1_tc_q;
        p1_prod_d  = p1_prod_q;
        acc_d      = acc_q;
        peak_d     = peak_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        out_vld_d  = out_vld_q;
        acc_out_d  = acc_out_q;
        peak_out_d = peak_out_q;
        cnt_out_d  = cnt_out_q;
        sat_out_d  = sat_out_q;

        if (!stall) begin
            p1_vld_d = accept;
            if (accept) begin
                p1_prod_d = prod_s1;
                p1_last_d = in_last;
                p1_tc_d   = tc_frame;
                busy_d    = ~in_last;
                tc_lat_d  = tc_frame;
            end

            // Not stalled means the output register is empty or being taken
            // this cycle, so it only stays valid if a new frame ends now.
            out_vld_d = 1'b0;

            if (p1_vld_q) begin
                if (p1_last_q) begin
                    out_vld_d  = 1'b1;
                    acc_out_d  = acc_next;
                    peak_out_d = peak_next;
                    cnt_out_d  = cnt_next;
                    sat_out_d  = sat_q | clip;
                    acc_d      = '0;
                    peak_d     = '0;
                    cnt_d      = '0;
                    sat_d      = 1'b0;
                end else begin
                    acc_d  = acc_next;
                    peak_d = peak_next;
                    cnt_d  = cnt_next;
                    sat_d  = sat_q | clip;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            tc_lat_q   <= 1'b0;
            p1_vld_q   <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_tc_q    <= 1'b0;
            p1_prod_q  <= '0;
            acc_q      <= '0;
            peak_q     <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            acc_out_q  <= '0;
            peak_out_q <= '0;
            cnt_out_q  <= '0;
            sat_out_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            tc_lat_q   <= tc_lat_d;
            p1_vld_q   <= p1_vld_d;
            p1_last_q  <= p1_last_d;
            p1_tc_q    <= p1_tc_d;
            p1_prod_q  <= p1_prod_d;
            acc_q      <= acc_d;
            peak_q     <= peak_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            out_vld_q  <= out_vld_d;
            acc_out_q  <= acc_out_d;
            peak_out_q <= peak_out_d;
            cnt_out_q  <= cnt_out_d;
            sat_out_q  <= sat_out_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign acc_out  = acc_out_q;
    assign peak_out = peak_out_q;
    assign cnt_out  = cnt_out_q;
    assign sat_flag = sat_out_q;

endmodule

// File: tb/tb_signed_mac_acc.sv
// Bench for signed_mac_acc: directed frames with literal results plus randomized frames against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs and handshakes are sampled on the falling edge.
// A second instance with a 16-bit accumulator covers signed negative clipping.
module tb_signed_mac_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tc, in_vld, in_rdy, in_last, out_vld, out_rdy, sat_flag;
    logic [7:0]  dat_a, dat_b;
    logic [23:0] acc_out;
    logic [15:0] peak_out, cnt_out;

    logic        tc1, in_vld1, in_rdy1, in_last1, out_vld1, out_rdy1, sat_flag1;
    logic [7:0]  dat_a1, dat_b1;
    logic [15:0] acc_out1, peak_out1, cnt_out1;

    signed_mac_acc #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .tc(tc), .in_vld(in_vld), .in_rdy(in_rdy),
        .dat_a(dat_a), .dat_b(dat_b), .in_last(in_last), .out_vld(out_vld),
        .out_rdy(out_rdy), .acc_out(acc_out), .peak_out(peak_out),
        .cnt_out(cnt_out), .sat_flag(sat_flag)
    );

    signed_mac_acc #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .tc(tc1), .in_vld(in_vld1), .in_rdy(in_rdy1),
        .dat_a(dat_a1), .dat_b(dat_b1), .in_last(in_last1), .out_vld(out_vld1),
        .out_rdy(out_rdy1), .acc_out(acc_out1), .peak_out(peak_out1),
        .cnt_out(cnt_out1), .sat_flag(sat_flag1)
    );

    int tests = 0;
    int fails = 0;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint acc;
        longint peak;
        longint cnt;
        longint sat;
    } res_t;

    res_t   exp_q[$];
    longint m_acc, m_peak, m_cnt;
    bit     m_sat, m_busy, m_tc;

    task automatic model_clear();
        m_acc = 0; m_peak = 0; m_cnt = 0; m_sat = 0; m_busy = 0; m_tc = 0;
    endtask

    task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input bit t_in, input bit last);
        bit     t;
        longint av, bv, p, lo, hi, mg;
        res_t   r;
        t  = m_busy ? m_tc : t_in;
        av = t ? longint'($signed(a)) : longint'(a);
        bv = t ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        lo = t ? -(longint'(1) << 23) : 0;
        hi = t ? (longint'(1) << 23) - 1 : (longint'(1) << 24) - 1;
        m_acc = m_acc + p;
        if (m_acc > hi) begin m_acc = hi; m_sat = 1; end
        if (m_acc < lo) begin m_acc = lo; m_sat = 1; end
        mg = (p < 0) ? -p : p;
        if (mg > m_peak) m_peak = mg;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        m_busy = 1; m_tc = t;
        if (last) begin
            r.acc = m_acc & 64'hFF_FFFF; r.peak = m_peak; r.cnt = m_cnt; r.sat = m_sat;
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    // Per-cycle checker: result contents, stall hold, ready rule; also feeds the model.
    task automatic monitor_loop();
        bit          prev_stall = 0;
        logic [23:0] p_acc;
        logic [15:0] p_peak, p_cnt;
        logic        p_sat;
        res_t        r;
        model_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_clear();
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_vld",  out_vld,  1);
                    chk("hold_acc",  acc_out,  p_acc);
                    chk("hold_peak", peak_out, p_peak);
                    chk("hold_cnt",  cnt_out,  p_cnt);
                    chk("hold_sat",  sat_flag, p_sat);
                end
                chk("in_rdy_rule", in_rdy, !(out_vld && !out_rdy));
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_result: got result acc=%0d, required no result", acc_out);
                    end else begin
                        r = exp_q.pop_front();
                        chk("res_acc",  acc_out,  r.acc);
                        chk("res_peak", peak_out, r.peak);
                        chk("res_cnt",  cnt_out,  r.cnt);
                        chk("res_sat",  sat_flag, r.sat);
                    end
                end
                prev_stall = out_vld && !out_rdy;
                p_acc = acc_out; p_peak = peak_out; p_cnt = cnt_out; p_sat = sat_flag;
                if (in_vld && in_rdy) model_beat(dat_a, dat_b, tc, in_last);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
        if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input int a, input int b, input bit last, input bit t);
        bit ok = 0;
        dat_a = a[7:0]; dat_b = b[7:0]; in_last = last; tc = t; in_vld = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); ok = in_rdy;
            step();
        end
        in_vld = 0; in_last = 0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_rdy stayed 0, required 1 within 200 cycles");
        end
    endtask

    // Called right after the last beat's accept edge: result must appear exactly one edge later.
    task automatic check_latency(input string nm);
        chk({nm, "_lat_n1"}, out_vld, 0);
        step();
        chk({nm, "_lat_n2"}, out_vld, 1);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'hFF;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic main_seq();
        int len;
        bit t;
        // reset state
        repeat (2) step();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_peak", peak_out, 0);
        chk("rst_cnt", cnt_out, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_in_rdy", in_rdy, 1);
        rst_n = 1;
        step();

        // signed mixed frame incl. (-128)*(-128)
        send_beat(-3, 4, 0, 1);
        send_beat(5, 5, 0, 1);
        send_beat(-128, -128, 1, 1);
        check_latency("t1");
        chk("t1_acc", acc_out, 16397);
        chk("t1_peak", peak_out, 16384);
        chk("t1_cnt", cnt_out, 3);
        chk("t1_sat", sat_flag, 0);

        // unsigned: just below and just above full scale
        for (int i = 0; i < 258; i++) send_beat(255, 255, i == 257, 0);
        check_latency("u258");
        chk("u258_acc", acc_out, 16776450);
        chk("u258_sat", sat_flag, 0);
        chk("u258_cnt", cnt_out, 258);
        for (int i = 0; i < 259; i++) send_beat(255, 255, i == 258, 0);
        check_latency("u259");
        chk("u259_acc", acc_out, 16777215);
        chk("u259_sat", sat_flag, 1);
        chk("u259_cnt", cnt_out, 259);
        chk("u259_peak", peak_out, 65025);

        // 16-bit accumulator: signed negative clip
        tc1 = 1; dat_a1 = 8'h80; dat_b1 = 8'h7F; in_vld1 = 1; in_last1 = 0;
        step(); step();
        in_last1 = 1;
        step();
        in_vld1 = 0; in_last1 = 0;
        chk("a16_lat_n1", out_vld1, 0);
        step();
        chk("a16_lat_n2", out_vld1, 1);
        chk("a16_acc", acc_out1, 16'h8000);
        chk("a16_sat", sat_flag1, 1);
        chk("a16_peak", peak_out1, 16256);
        chk("a16_cnt", cnt_out1, 3);

        // back-pressure: held result blocks a pending beat
        out_rdy = 0;
        send_beat(3, 3, 1, 1);
        check_latency("bp1");
        chk("bp1_acc", acc_out, 9);
        dat_a = 8'd10; dat_b = 8'hFE; in_last = 1; tc = 1; in_vld = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_in_rdy", in_rdy, 0);
            chk("bp_acc_hold", acc_out, 9);
            chk("bp_vld_hold", out_vld, 1);
        end
        out_rdy = 1;
        send_beat(10, -2, 1, 1);
        check_latency("bp2");
        chk("bp2_acc", acc_out, 24'hFFFFEC);
        chk("bp2_peak", peak_out, 20);
        chk("bp2_cnt", cnt_out, 1);

        // tc changes mid-frame; frame keeps signed meaning
        send_beat(-1, -1, 0, 1);
        send_beat(2, -1, 1, 0);
        check_latency("tct");
        chk("tct_acc", acc_out, 24'hFFFFFF);
        chk("tct_peak", peak_out, 2);

        // reset in the middle of a frame
        send_beat(7, 7, 0, 0);
        send_beat(7, 7, 0, 0);
        rst_n = 0;
        #1;
        chk("mrst_out_vld", out_vld, 0);
        chk("mrst_acc", acc_out, 0);
        chk("mrst_peak", peak_out, 0);
        chk("mrst_cnt", cnt_out, 0);
        chk("mrst_sat", sat_flag, 0);
        chk("mrst_in_rdy", in_rdy, 1);
        step(); step();
        rst_n = 1;
        step();
        send_beat(7, 6, 1, 0);
        check_latency("mrst2");
        chk("mrst2_acc", acc_out, 42);
        chk("mrst2_cnt", cnt_out, 1);
        chk("mrst2_peak", peak_out, 42);

        // randomized frames: bubbles, random out_rdy, random tc per beat
        rnd_rdy = 1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            t = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) step();
                send_beat(pick(), pick(), k == len - 1, (k == 0) ? t : 1'($urandom_range(0, 1)));
            end
        end
        rnd_rdy = 0;
        out_rdy = 1;
        repeat (10) step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 0; tc = 0; in_vld = 0; in_last = 0; dat_a = 0; dat_b = 0; out_rdy = 1;
        tc1 = 0; in_vld1 = 0; in_last1 = 0; dat_a1 = 0; dat_b1 = 0; out_rdy1 = 1;
        fork
            monitor_loop();
            main_seq();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
